bit_serial_add_seq: RTL and testbench



---
 rtl/bsa_pkg.sv | 22 ++
 rtl/serial_add_core.sv | 70 +++++++
 rtl/bit_serial_add_seq.sv | 158 +++++++++++++++
 tb/tb_bit_serial_add_seq.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/bsa_pkg.sv
// Shared types and sizing for the bit-serial adder sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bsa_pkg;

   // Default operand / sum width in bits.
   localparam int BSA_WIDTH = 8;

   // Sequencer states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } bsa_state_t;

   // Width of the bit counter that walks 0..width-1 during SHIFT.
   function automatic int bsa_cnt_w(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/serial_add_core.sv
// Bit-serial add datapath: two PISO operand registers, carry FF, full-adder cell, SIPO sum.
// Latency: one result bit per shift_en cycle, LSB first; WIDTH shifts for a full sum.
// Backpressure: none; the sequencer owns load/shift_en and the core obeys every cycle.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   load            parallel-load a_in/b_in into the PISOs, cin into the carry FF
//   shift_en        add the current LSBs, shift operands right, push sum bit into SIPO MSB
//   a_in, b_in, cin operands and carry-in for load
//   sipo_q          SIPO contents (sum bits accumulated so far, newest at the MSB)
//   sum_bit         full-adder sum output for the current LSBs
//   carry           full-adder carry output, i.e. the value the carry FF takes on this shift
module serial_add_core
   import bsa_pkg::*;
#(
   parameter int WIDTH = BSA_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift_en,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin,
   output logic [WIDTH-1:0] sipo_q,
   output logic             sum_bit,
   output logic             carry
);

   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sipo_d;
   logic             carry_q, carry_d;

   // Full-adder cell on the operand LSBs and the running carry.
   assign sum_bit = a_q[0] ^ b_q[0] ^ carry_q;
   assign carry   = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      sipo_d  = sipo_q;
      carry_d = carry_q;
      if (load) begin
         a_d     = a_in;
         b_d     = b_in;
         carry_d = cin;
      end else if (shift_en) begin
         a_d     = {1'b0, a_q[WIDTH-1:1]};
         b_d     = {1'b0, b_q[WIDTH-1:1]};
         sipo_d  = {sum_bit, sipo_q[WIDTH-1:1]};
         carry_d = carry;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         sipo_q  <= '0;
         carry_q <= 1'b0;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         sipo_q  <= sipo_d;
         carry_q <= carry_d;
      end
   end

endmodule

// File: rtl/bit_serial_add_seq.sv
// Sequencer for the bit-serial adder: latches operands on start, runs WIDTH serial add steps, presents sum/cout.
// Latency: start accepted at edge k -> done and new sum visible in cycle k+WIDTH+2; next start accepted WIDTH+3 later.
// Backpressure: none; start is only sampled in IDLE and is silently ignored while busy (no queuing).
//
// Ports:
//   clk, rst   clock, synchronous active-high reset (wins over start)
//   start      request, sampled only in IDLE
//   a, b, cin  operands, latched on the accepting edge only
//   busy       high in LOAD, SHIFT and DONE
//   done       one-cycle pulse in DONE
//   sum, cout  registered result and final carry; change only on the edge that enters DONE
//   ovf        signed overflow, present only when BSA_OVF_EN is defined
module bit_serial_add_seq
   import bsa_pkg::*;
#(
   parameter int WIDTH = BSA_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef BSA_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int                 CNT_W    = bsa_cnt_w(WIDTH);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

   bsa_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_lat_q, a_lat_d;
   logic [WIDTH-1:0] b_lat_q, b_lat_d;
   logic             cin_lat_q, cin_lat_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
`ifdef BSA_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   logic             load;
   logic             shift_en;
   logic [WIDTH-1:0] sipo_q;
   logic             sum_bit;
   logic             carry;

   serial_add_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .shift_en (shift_en),
      .a_in     (a_lat_q),
      .b_in     (b_lat_q),
      .cin      (cin_lat_q),
      .sipo_q   (sipo_q),
      .sum_bit  (sum_bit),
      .carry    (carry)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      a_lat_d   = a_lat_q;
      b_lat_d   = b_lat_q;
      cin_lat_d = cin_lat_q;
      sum_d     = sum_q;
      cout_d    = cout_q;
`ifdef BSA_OVF_EN
      ovf_d     = ovf_q;
`endif
      load      = 1'b0;
      shift_en  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_lat_d   = a;
               b_lat_d   = b;
               cin_lat_d = cin;
               state_d   = LOAD;
            end
         end
         LOAD: begin
            load    = 1'b1;
            cnt_d   = '0;
            state_d = SHIFT;
         end
         SHIFT: begin
            shift_en = 1'b1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
               cnt_d   = '0;
               // The SIPO takes its last bit on this same edge, so the output
               // register captures the forwarded value rather than sipo_q, which
               // lets sum/cout appear together with done.
               sum_d   = {sum_bit, sipo_q[WIDTH-1:1]};
               cout_d  = carry;
`ifdef BSA_OVF_EN
               // Carry into the MSB is recovered from the MSB adder inputs and
               // its sum output; overflow is that carry XOR the carry out.
               ovf_d   = (sum_bit ^ a_lat_q[WIDTH-1] ^ b_lat_q[WIDTH-1]) ^ carry;
`endif
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         a_lat_q   <= '0;
         b_lat_q   <= '0;
         cin_lat_q <= 1'b0;
         sum_q     <= '0;
         cout_q    <= 1'b0;
`ifdef BSA_OVF_EN
         ovf_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         a_lat_q   <= a_lat_d;
         b_lat_q   <= b_lat_d;
         cin_lat_q <= cin_lat_d;
         sum_q     <= sum_d;
         cout_q    <= cout_d;
`ifdef BSA_OVF_EN
         ovf_q     <= ovf_d;
`endif
      end
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
`ifdef BSA_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_bit_serial_add_seq.sv
// Testbench for bit_serial_add_seq: directed and random adds against an arithmetic reference model.
// Timing: inputs driven and outputs sampled on the falling edge; done events time-stamped by edge count.
// Flow: every wait is a fixed number of cycles, so the run always ends at the summary line.
module tb_bit_serial_add_seq;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   typedef struct {
      int           t;
      logic [W-1:0] s;
      logic         c;
      logic         o;
   } done_ev_t;

   done_ev_t     dq[$];
   logic [W-1:0] prev_sum;
   logic         prev_cout;

   bit_serial_add_seq #(
      .WIDTH (W)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
`ifdef BSA_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

`ifndef BSA_OVF_EN
   assign ovf = 1'b0;
`endif

   always #5 clk = ~clk;

   // cyc = number of rising edges so far; a value sampled on the falling edge
   // with cyc==n belongs to cycle n.
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (done === 1'b1) dq.push_back('{cyc, sum, cout, ovf});
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: {ovf, cout, sum} from plain integer addition.
   function automatic logic [W+1:0] model(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic cc);
      logic [W:0] t;
      logic       o;
      t = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, cc};
      o = (aa[W-1] == bb[W-1]) && (t[W-1] != aa[W-1]);
      return {o, t};
   endfunction

   // One start pulse, then full result/timing check; operands are scrambled
   // right after the accepting edge to prove they were latched.
   task automatic run_check(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic cc, input string tag);
      int           t0;
      logic [W+1:0] m;
      m = model(aa, bb, cc);
      dq.delete();
      @(negedge clk);
      a = aa; b = bb; cin = cc; start = 1'b1; t0 = cyc;
      @(negedge clk);
      start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      check_eq({tag, "/busy_rise"}, 64'(busy), 64'(1));
      check_eq({tag, "/sum_hold"}, 64'({cout, sum}), 64'({prev_cout, prev_sum}));
      repeat (W + 4) @(negedge clk);
      check_eq({tag, "/n_done"}, 64'(dq.size()), 64'(1));
      if (dq.size() > 0) begin
         check_eq({tag, "/done_cyc"}, 64'(dq[0].t), 64'(t0 + W + 2));
         check_eq({tag, "/sum"}, 64'(dq[0].s), 64'(m[W-1:0]));
         check_eq({tag, "/cout"}, 64'(dq[0].c), 64'(m[W]));
`ifdef BSA_OVF_EN
         check_eq({tag, "/ovf"}, 64'(dq[0].o), 64'(m[W+1]));
`endif
      end
      check_eq({tag, "/busy_fall"}, 64'(busy), 64'(0));
      check_eq({tag, "/sum_after"}, 64'(sum), 64'(m[W-1:0]));
      prev_sum  = m[W-1:0];
      prev_cout = m[W];
   endtask

   initial begin
      int t0;

      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst/busy", 64'(busy), 64'(0));
      check_eq("rst/done", 64'(done), 64'(0));
      check_eq("rst/sum",  64'(sum),  64'(0));
      check_eq("rst/cout", 64'(cout), 64'(0));
`ifdef BSA_OVF_EN
      check_eq("rst/ovf",  64'(ovf),  64'(0));
`endif
      rst = 1'b0;
      prev_sum = '0; prev_cout = 1'b0;

      // Directed vectors.
      run_check(8'h69, 8'h34, 1'b0, "d69_34");
      run_check(8'hFF, 8'h01, 1'b0, "dFF_01");
      run_check(8'hFF, 8'h00, 1'b1, "dFF_00c");
      run_check(8'h7F, 8'h01, 1'b0, "d7F_01");
      run_check(8'h80, 8'h80, 1'b0, "d80_80");
      run_check(8'h00, 8'h00, 1'b0, "d00_00");

      // Random vectors.
      for (int i = 0; i < 16; i++) begin
         run_check(W'($urandom), W'($urandom), 1'($urandom), $sformatf("rnd%0d", i));
      end

      // A second start while busy is dropped.
      dq.delete();
      @(negedge clk);
      a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1; t0 = cyc;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      a = 8'h01; b = 8'h01; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (25) @(negedge clk);
      check_eq("ign/n_done", 64'(dq.size()), 64'(1));
      if (dq.size() > 0) begin
         check_eq("ign/done_cyc", 64'(dq[0].t), 64'(t0 + W + 2));
         check_eq("ign/sum", 64'(dq[0].s), 64'(8'h30));
      end
      prev_sum = 8'h30; prev_cout = 1'b0;

      // Reset in the middle of SHIFT aborts without a done.
      dq.delete();
      @(negedge clk);
      a = 8'h5A; b = 8'h33; cin = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_eq("abort/busy", 64'(busy), 64'(0));
      check_eq("abort/done", 64'(done), 64'(0));
      check_eq("abort/sum",  64'(sum),  64'(0));
      check_eq("abort/cout", 64'(cout), 64'(0));
      rst = 1'b0;
      repeat (15) @(negedge clk);
      check_eq("abort/n_done", 64'(dq.size()), 64'(0));
      prev_sum = '0; prev_cout = 1'b0;
      run_check(8'h05, 8'h03, 1'b0, "post_rst");

      // rst and start together in IDLE: rst wins, nothing starts.
      dq.delete();
      @(negedge clk);
      a = 8'h11; b = 8'h22; rst = 1'b1; start = 1'b1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      check_eq("rst_start/busy", 64'(busy), 64'(0));
      repeat (15) @(negedge clk);
      check_eq("rst_start/n_done", 64'(dq.size()), 64'(0));
      check_eq("rst_start/sum", 64'(sum), 64'(0));

      // start held high for 30 cycles re-triggers every WIDTH+3 cycles.
      dq.delete();
      @(negedge clk);
      a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1; t0 = cyc;
      repeat (30) @(negedge clk);
      start = 1'b0;
      repeat (15) @(negedge clk);
      check_eq("hold/n_done", 64'(dq.size()), 64'(3));
      for (int i = 0; i < dq.size() && i < 3; i++) begin
         check_eq($sformatf("hold/done_cyc%0d", i), 64'(dq[i].t), 64'(t0 + W + 2 + i * (W + 3)));
         check_eq($sformatf("hold/sum%0d", i), 64'(dq[i].s), 64'(8'h02));
         check_eq($sformatf("hold/cout%0d", i), 64'(dq[i].c), 64'(0));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
